// File: rtl/audio_att_scaler_if.sv
// Stereo PCM stream interface for audio_att_scaler.
// Carries the input frame handshake (in_*) and the scaled output frame
// handshake (out_*). The scaler connects through the slave modport; the
// frame source/sink side (e.g. a testbench or upstream glue) uses master.
interface audio_att_scaler_if #(
  parameter int SAMPLE_W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] in_left;
  logic [SAMPLE_W-1:0] in_right;
  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_left;
  logic [SAMPLE_W-1:0] out_right;

  modport master (
    output in_valid, in_left, in_right, out_ready,
    input  in_ready, out_valid, out_left, out_right
  );

  modport slave (
    input  in_valid, in_left, in_right, out_ready,
    output in_ready, out_valid, out_left, out_right
  );
endinterface

// File: rtl/audio_att_scaler.sv
// audio_att_scaler
// Applies decoded NeXT attenuation (2 dB per index, 44 = mute) to a stereo
// PCM stream. A single time-shared signed x unsigned Q1.16 multiplier scales
// the left sample, then the right sample, of each accepted frame.
// Optional feature macro: RAMP_AUDIO_ATT_EN
//   defined   : the in-use index of each channel walks one step toward its
//               target every RAMP_SAMPLES accepted frames (soft volume ramp).
//   undefined : the in-use index jumps straight to the target at every
//               accepted frame and is applied to that same frame.
module audio_att_scaler #(
  parameter int SAMPLE_W     = 16,
  parameter int RAMP_SAMPLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       db_valid,
  input  logic       is_muted,
  input  logic [5:0] lch_db,
  input  logic [5:0] rch_db,
  audio_att_scaler_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL_L = 2'd1;
  localparam logic [1:0] ST_MUL_R = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [5:0] IDX_MAX  = 6'd43;
  localparam logic [5:0] IDX_MUTE = 6'd44;

  localparam int PROD_W = SAMPLE_W + 18;

  if (RAMP_SAMPLES < 1) begin : g_bad_ramp_samples
    $error("audio_att_scaler: RAMP_SAMPLES must be at least 1");
  end

  // Unsigned Q1.16 gain for each attenuation index; index 44 and above is mute.
  function automatic logic [16:0] gain_rom(input logic [5:0] k);
    logic [16:0] g;
    case (k)
      6'd0:  g = 17'd65536;  6'd1:  g = 17'd52057;  6'd2:  g = 17'd41350;
      6'd3:  g = 17'd32846;  6'd4:  g = 17'd26090;  6'd5:  g = 17'd20724;
      6'd6:  g = 17'd16462;  6'd7:  g = 17'd13076;  6'd8:  g = 17'd10387;
      6'd9:  g = 17'd8250;   6'd10: g = 17'd6554;   6'd11: g = 17'd5206;
      6'd12: g = 17'd4135;   6'd13: g = 17'd3285;   6'd14: g = 17'd2609;
      6'd15: g = 17'd2072;   6'd16: g = 17'd1646;   6'd17: g = 17'd1308;
      6'd18: g = 17'd1039;   6'd19: g = 17'd825;    6'd20: g = 17'd655;
      6'd21: g = 17'd521;    6'd22: g = 17'd414;    6'd23: g = 17'd328;
      6'd24: g = 17'd261;    6'd25: g = 17'd207;    6'd26: g = 17'd165;
      6'd27: g = 17'd131;    6'd28: g = 17'd104;    6'd29: g = 17'd83;
      6'd30: g = 17'd66;     6'd31: g = 17'd52;     6'd32: g = 17'd41;
      6'd33: g = 17'd33;     6'd34: g = 17'd26;     6'd35: g = 17'd21;
      6'd36: g = 17'd16;     6'd37: g = 17'd13;     6'd38: g = 17'd10;
      6'd39: g = 17'd8;      6'd40: g = 17'd7;      6'd41: g = 17'd5;
      6'd42: g = 17'd4;      6'd43: g = 17'd3;
      default: g = 17'd0;
    endcase
    return g;
  endfunction

  // Index a channel should settle on: mute when muted or the decode is stale,
  // otherwise the requested index clamped to the last audible step.
  function automatic logic [5:0] target_idx(input logic [5:0] db,
                                             input logic dv, input logic mu);
    logic [5:0] t;
    if (mu || !dv)          t = IDX_MUTE;
    else if (db > IDX_MAX)  t = IDX_MAX;
    else                    t = db;
    return t;
  endfunction

  logic [1:0]          state;
  logic                accept;
  logic [SAMPLE_W-1:0] smp_l;
  logic [SAMPLE_W-1:0] smp_r;
  logic [5:0]          cur_l;
  logic [5:0]          cur_r;
  logic [5:0]          tgt_l;
  logic [5:0]          tgt_r;
  logic [5:0]          use_l;
  logic [5:0]          use_r;
  logic [SAMPLE_W-1:0] out_l_q;
  logic [SAMPLE_W-1:0] out_r_q;

  logic signed [SAMPLE_W-1:0] mul_a;
  logic        [16:0]         mul_g;
  logic signed [PROD_W-1:0]   mul_p;
  logic        [SAMPLE_W-1:0] scaled;
  logic                       unused_prod_bits;

  assign accept = (state == ST_IDLE) && bus.in_valid;
  assign tgt_l  = target_idx(lch_db, db_valid, is_muted);
  assign tgt_r  = target_idx(rch_db, db_valid, is_muted);

  // Frame sequencer: accept in IDLE, scale L then R, hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state <= ST_MUL_L;
        ST_MUL_L: state <= ST_MUL_R;
        ST_MUL_R: state <= ST_OUT;
        ST_OUT:   if (bus.out_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef RAMP_AUDIO_ATT_EN
  localparam int CNT_W = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_SAMPLES - 1);

  logic [CNT_W-1:0] ramp_cnt;
  logic [5:0]       frm_l;
  logic [5:0]       frm_r;

  // One index step toward the target, or stay put once it is reached.
  function automatic logic [5:0] step_toward(input logic [5:0] cur,
                                              input logic [5:0] tgt);
    logic [5:0] n;
    if (cur > tgt)      n = cur - 6'd1;
    else if (cur < tgt) n = cur + 6'd1;
    else                n = cur;
    return n;
  endfunction

  // Latch the frame with the current indices, then advance the ramp so any
  // index change takes effect from the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_l    <= '0;
      smp_r    <= '0;
      frm_l    <= IDX_MUTE;
      frm_r    <= IDX_MUTE;
      cur_l    <= IDX_MUTE;
      cur_r    <= IDX_MUTE;
      ramp_cnt <= '0;
    end else if (accept) begin
      smp_l <= bus.in_left;
      smp_r <= bus.in_right;
      frm_l <= cur_l;
      frm_r <= cur_r;
      if (ramp_cnt == CNT_LAST) begin
        cur_l    <= step_toward(cur_l, tgt_l);
        cur_r    <= step_toward(cur_r, tgt_r);
        ramp_cnt <= '0;
      end else begin
        ramp_cnt <= ramp_cnt + CNT_W'(1);
      end
    end
  end

  assign use_l = frm_l;
  assign use_r = frm_r;
`else
  // Latch the frame and jump straight to the target indices for this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_l <= '0;
      smp_r <= '0;
      cur_l <= IDX_MUTE;
      cur_r <= IDX_MUTE;
    end else if (accept) begin
      smp_l <= bus.in_left;
      smp_r <= bus.in_right;
      cur_l <= tgt_l;
      cur_r <= tgt_r;
    end
  end

  assign use_l = cur_l;
  assign use_r = cur_r;
`endif

  // Steer the shared multiplier to the channel the sequencer is working on.
  always_comb begin
    mul_a = $signed(smp_l);
    mul_g = gain_rom(use_l);
    if (state == ST_MUL_R) begin
      mul_a = $signed(smp_r);
      mul_g = gain_rom(use_r);
    end
  end

  // Gain never exceeds unity, so the floor-shifted product always fits SAMPLE_W.
  assign mul_p            = mul_a * $signed({1'b0, mul_g});
  assign scaled           = mul_p[16 +: SAMPLE_W];
  assign unused_prod_bits = ^{mul_p[15:0], mul_p[PROD_W-1:SAMPLE_W+16]};

  // Capture each scaled channel in its multiply slot; held through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_l_q <= '0;
      out_r_q <= '0;
    end else begin
      if (state == ST_MUL_L) out_l_q <= scaled;
      if (state == ST_MUL_R) out_r_q <= scaled;
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.out_left  = out_l_q;
  assign bus.out_right = out_r_q;

endmodule

// File: tb/tb_audio_att_scaler.sv
// Testbench for audio_att_scaler: directed cases plus randomized frames
// checked against a reference model that derives gains from the dB law and
// scales with plain integer floor division.
module tb_audio_att_scaler;
  localparam int SW = 16;
  localparam int RS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       db_valid = 1'b0;
  logic       is_muted = 1'b0;
  logic [5:0] lch_db = '0;
  logic [5:0] rch_db = '0;

  audio_att_scaler_if #(.SAMPLE_W(SW)) bus ();

  audio_att_scaler #(.SAMPLE_W(SW), .RAMP_SAMPLES(RS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .db_valid (db_valid),
    .is_muted (is_muted),
    .lch_db   (lch_db),
    .rch_db   (rch_db),
    .bus      (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_cur_l = 44;
  int m_cur_r = 44;
  int m_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Amplitude gain of k steps of 2 dB, rounded to Q1.16; 44 and above is silence.
  function automatic int gainModel(input int k);
    real a;
    if (k >= 44) return 0;
    a = 65536.0 * (10.0 ** (-real'(k) / 10.0));
    return $rtoi(a + 0.5);
  endfunction

  function automatic logic [15:0] scaleModel(input logic [15:0] s, input int k);
    longint p;
    longint q;
    p = longint'($signed(s)) * longint'(gainModel(k));
    q = p / 65536;
    if (p < 0 && (p % 65536) != 0) q = q - 1;
    return q[15:0];
  endfunction

  function automatic int targetModel(input int db, input bit dv, input bit mu);
    if (mu || !dv) return 44;
    return (db > 43) ? 43 : db;
  endfunction

  task automatic modelReset();
    m_cur_l = 44;
    m_cur_r = 44;
    m_cnt   = 0;
  endtask

  task automatic modelAccept(input int tl, input int tr, output int gl, output int gr);
`ifdef RAMP_AUDIO_ATT_EN
    gl = m_cur_l;
    gr = m_cur_r;
    if (m_cnt == RS - 1) begin
      if (tl > m_cur_l) m_cur_l++; else if (tl < m_cur_l) m_cur_l--;
      if (tr > m_cur_r) m_cur_r++; else if (tr < m_cur_r) m_cur_r--;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
`else
    m_cur_l = tl;
    m_cur_r = tr;
    gl = tl;
    gr = tr;
`endif
  endtask

  // Push one frame, check exact latency, optional output stall, and return to IDLE.
  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r,
                               input bit dv, input bit mu, input int ldb, input int rdb,
                               input int stall, output logic [15:0] got_l,
                               output logic [15:0] got_r);
    int n;
    int tl;
    int tr;
    int gl;
    int gr;
    logic [15:0] el;
    logic [15:0] er;
    n = 0;
    got_l = '0;
    got_r = '0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checkOutput("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    db_valid      = dv;
    is_muted      = mu;
    lch_db        = 6'(ldb);
    rch_db        = 6'(rdb);
    bus.in_left   = l;
    bus.in_right  = r;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    tl = targetModel(ldb, dv, mu);
    tr = targetModel(rdb, dv, mu);
    modelAccept(tl, tr, gl, gr);
    el = scaleModel(l, gl);
    er = scaleModel(r, gr);
    @(posedge clk);
    #1;
    bus.in_left  = 16'($urandom);
    bus.in_right = 16'($urandom);
    lch_db       = 6'($urandom_range(0, 63));
    is_muted     = 1'($urandom);
    @(negedge clk);
    checkOutput("lat1_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("busy_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("lat2_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat3_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("out_left", 32'(bus.out_left), 32'(el));
    checkOutput("out_right", 32'(bus.out_right), 32'(er));
    got_l = bus.out_left;
    got_r = bus.out_right;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("stall_left", 32'(bus.out_left), 32'(el));
      checkOutput("stall_right", 32'(bus.out_right), 32'(er));
      checkOutput("stall_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("drop_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("idle_ready", 32'(bus.in_ready), 32'd1);
  endtask

  logic [15:0] gl_v;
  logic [15:0] gr_v;
  logic [15:0] prev_l;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_left   = '0;
    bus.in_right  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_left", 32'(bus.out_left), 32'd0);
    checkOutput("rst_out_right", 32'(bus.out_right), 32'd0);
    rst_n = 1'b1;
    modelReset();

    applyStimulus(16'h4000, 16'h4000, 1'b0, 1'b0, 0, 0, 0, gl_v, gr_v);
    checkOutput("t1_left", 32'(gl_v), 32'h0);
    checkOutput("t1_right", 32'(gr_v), 32'h0);

`ifndef RAMP_AUDIO_ATT_EN
    applyStimulus(16'h4000, 16'h8000, 1'b1, 1'b0, 0, 0, 0, gl_v, gr_v);
    checkOutput("t2_left", 32'(gl_v), 32'h4000);
    checkOutput("t2_right", 32'(gr_v), 32'h8000);
    applyStimulus(16'h4000, 16'h7FFF, 1'b1, 1'b0, 3, 50, 0, gl_v, gr_v);
    checkOutput("t3_left", 32'(gl_v), 32'h2013);
    checkOutput("t3_right", 32'(gr_v), 32'h0001);
`endif

    // Output stall with in_valid held high throughout.
    applyStimulus(16'h1234, 16'hEDCB, 1'b1, 1'b0, 1, 2, 5, gl_v, gr_v);

    for (int f = 0; f < 40; f++) begin
      applyStimulus(16'($urandom), 16'($urandom), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 9) == 0), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 63)), int'($urandom_range(0, 2)),
                    gl_v, gr_v);
    end

    // Asynchronous reset while the right channel is being scaled.
    @(negedge clk);
    db_valid     = 1'b1;
    is_muted     = 1'b0;
    lch_db       = 6'd0;
    rch_db       = 6'd0;
    bus.in_left  = 16'h7FFF;
    bus.in_right = 16'h7FFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("mrst_out_left", 32'(bus.out_left), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no_stale_frame", 32'(bus.out_valid), 32'd0);
    end

`ifdef RAMP_AUDIO_ATT_EN
    // Unmute ramp from full attenuation to unity on a DC input.
    prev_l = '0;
    for (int f = 0; f < 180; f++) begin
      applyStimulus(16'h4000, 16'h4000, 1'b1, 1'b0, 0, 0, 0, gl_v, gr_v);
      checkOutput("ramp_monotonic", 32'($signed(gl_v) >= $signed(prev_l)), 32'd1);
      prev_l = gl_v;
    end
    checkOutput("ramp_final", 32'(gl_v), 32'h4000);
`else
    applyStimulus(16'h8000, 16'hFFFF, 1'b1, 1'b0, 0, 43, 0, gl_v, gr_v);
    checkOutput("min_unity", 32'(gl_v), 32'h8000);
    checkOutput("neg_floor", 32'(gr_v), 32'hFFFF);
`endif

    for (int f = 0; f < 10; f++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'b1, 1'b0,
                    int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 1)), gl_v, gr_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
